ws_pixel_serializer: RTL and testbench

WS_PIXEL_SERIALIZER -- requirements
Module: ws_pixel_serializer

---
 rtl/ws_pkg.sv | 15 +
 rtl/ws_bit_timer.sv | 31 +++
 rtl/ws_pixel_serializer.sv | 108 ++++++++++
 tb/tb_ws_pixel_serializer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws_pkg.sv
// Shared constants and state type for the WS281x pixel path
// (serializer and downstream bit encoder).
package ws_pkg;

   localparam int WS_BIT_PERIOD   = 16;
   localparam int WS_NUM_BITS     = 24;
   localparam int WS_RESET_CYCLES = 4000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } ws_state_e;

endpackage

// File: rtl/ws_bit_timer.sv
// Bit-period phase counter: counts 0..BIT_PERIOD-1 and wraps.
// wrap_o flags the last cycle of a period; clr_i forces phase to 0 next cycle.
module ws_bit_timer
   import ws_pkg::*;
#(
   parameter int BIT_PERIOD = WS_BIT_PERIOD,
   parameter int PW         = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   output logic [PW-1:0] phase_o,
   output logic          wrap_o
);

   logic [PW-1:0] phase_q, phase_d;

   assign wrap_o  = (phase_q == PW'(BIT_PERIOD - 1));
   assign phase_o = phase_q;

   always_comb begin
      phase_d = phase_q + 1'b1;
      if (clr_i || wrap_o) phase_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) phase_q <= '0;
      else     phase_q <= phase_d;
   end

endmodule

// File: rtl/ws_pixel_serializer.sv
// Serializes pixel words MSB first, one bit per BIT_PERIOD clocks, then holds
// the line low for RESET_CYCLES as the latch gap after each frame.
module ws_pixel_serializer
   import ws_pkg::*;
#(
   parameter int BIT_PERIOD   = WS_BIT_PERIOD,
   parameter int NUM_BITS     = WS_NUM_BITS,
   parameter int RESET_CYCLES = WS_RESET_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_BITS-1:0] pix_data,
   input  logic                pix_valid,
   input  logic                pix_last,
   output logic                pix_ready,
   output logic                digit,
   output logic                bit_strobe,
   output logic                tx_en,
   output logic                latch,
   output logic                underrun
);

   localparam int PW = (BIT_PERIOD > 1)   ? $clog2(BIT_PERIOD)   : 1;
   localparam int BW = (NUM_BITS > 1)     ? $clog2(NUM_BITS)     : 1;
   localparam int LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   ws_state_e           state_q, state_d;
   logic [NUM_BITS-1:0] shreg_q, shreg_d;
   logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
   logic                last_q, last_d;
   logic [LW-1:0]       lat_cnt_q, lat_cnt_d;

   logic [PW-1:0] phase;
   logic          wrap;
   logic          at_end;
   logic          accept;
   logic          in_shift;

   assign in_shift = (state_q == ST_SHIFT);
   assign at_end   = in_shift && wrap && (bit_cnt_q == BW'(NUM_BITS - 1));

   // Mid-frame a new pixel is only taken on the very last cycle of the
   // final bit, so reloads are gapless.
   assign pix_ready = !rst && ((state_q == ST_IDLE) || (at_end && !last_q));
   assign accept    = pix_valid && pix_ready;

   assign digit      = in_shift && shreg_q[NUM_BITS-1];
   assign bit_strobe = in_shift && (phase == '0);
   assign tx_en      = in_shift;
   assign latch      = (state_q == ST_LATCH);
   assign underrun   = at_end && !last_q && !pix_valid;

   ws_bit_timer #(.BIT_PERIOD(BIT_PERIOD), .PW(PW)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (accept || !in_shift),
      .phase_o (phase),
      .wrap_o  (wrap)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      last_d    = last_q;
      lat_cnt_d = lat_cnt_q;
      if (accept) begin
         state_d   = ST_SHIFT;
         shreg_d   = pix_data;
         last_d    = pix_last;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            ST_SHIFT: begin
               if (at_end) begin
                  state_d   = ST_LATCH;
                  lat_cnt_d = '0;
               end else if (wrap) begin
                  shreg_d   = {shreg_q[NUM_BITS-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            ST_LATCH: begin
               if (lat_cnt_q == LW'(RESET_CYCLES - 1)) state_d = ST_IDLE;
               else lat_cnt_d = lat_cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         last_q    <= 1'b0;
         lat_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         last_q    <= last_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

endmodule

// File: tb/tb_ws_pixel_serializer.sv
// Randomized + directed bench for ws_pixel_serializer against a
// cycle-index reference model of the serial frame timing.
module tb_ws_pixel_serializer;

   localparam int BP = 16;
   localparam int NB = 24;
   localparam int RC = 4000;
   localparam int PIX_CYC = BP * NB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] pix_data = '0;
   logic          pix_valid = 1'b0;
   logic          pix_last = 1'b0;
   logic          pix_ready, digit, bit_strobe, tx_en, latch, underrun;

   int vecs = 0;
   int errs = 0;

   ws_pixel_serializer #(.BIT_PERIOD(BP), .NUM_BITS(NB), .RESET_CYCLES(RC)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_last   (pix_last),
      .pix_ready  (pix_ready),
      .digit      (digit),
      .bit_strobe (bit_strobe),
      .tx_en      (tx_en),
      .latch      (latch),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   // Model: mode 0 idle, 1 transmitting (m_t = cycle within pixel), 2 latch gap.
   int            m_mode = 0;
   int            m_t    = 0;
   int            m_lat  = 0;
   logic [NB-1:0] m_word = '0;
   logic          m_last = 1'b0;

   function automatic logic [5:0] model_out();
      logic rdy, dg, sb, te, la, ur, fin;
      rdy = 0; dg = 0; sb = 0; te = 0; la = 0; ur = 0;
      if (!rst) begin
         if (m_mode == 0) rdy = 1;
         else if (m_mode == 1) begin
            fin = (m_t == PIX_CYC - 1);
            dg  = m_word[NB - 1 - m_t / BP];
            sb  = (m_t % BP == 0);
            te  = 1;
            rdy = fin && !m_last;
            ur  = fin && !m_last && !pix_valid;
         end else la = 1;
      end
      return {rdy, dg, sb, te, la, ur};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0; m_t = 0; m_lat = 0;
      end else begin
         logic [5:0] e;
         e = model_out();
         if (pix_valid && e[5]) begin
            m_mode = 1; m_t = 0; m_word = pix_data; m_last = pix_last;
         end else if (m_mode == 1) begin
            if (m_t == PIX_CYC - 1) begin m_mode = 2; m_lat = 0; end
            else m_t++;
         end else if (m_mode == 2) begin
            if (m_lat == RC - 1) m_mode = 0;
            else m_lat++;
         end
      end
   end

   always @(negedge clk) begin
      logic [5:0] e, a;
      e = model_out();
      a = {pix_ready, digit, bit_strobe, tx_en, latch, underrun};
      vecs++;
      if (a !== e) begin
         errs++;
         $display("FAIL cycle_model t=%0t {ready,digit,strobe,tx_en,latch,underrun} got=%b exp=%b",
                  $time, a, e);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Single pixel 0xA50000, last=1: strobes, digit sequence, latch length.
      begin
         int sc, lc, prev, gaperr;
         logic [NB-1:0] dseq;
         sc = 0; lc = 0; prev = 0; gaperr = 0; dseq = '0;
         pix_valid = 1; pix_data = 24'hA50000; pix_last = 1;
         tick();
         pix_valid = 0; pix_data = 24'hFFFFFF;
         for (int n = 0; n < PIX_CYC + RC + 4; n++) begin
            @(negedge clk);
            if (bit_strobe) begin
               if (sc > 0 && n - prev != BP) gaperr++;
               prev = n; sc++;
               dseq = {dseq[NB-2:0], digit};
            end
            if (latch) lc++;
         end
         chk("d1_strobes", sc, 24);
         chk("d1_digits", int'(dseq), 32'hA50000);
         chk("d1_strobe_spacing_errs", gaperr, 0);
         chk("d1_latch_cycles", lc, RC);
         chk("d1_idle_ready", int'(pix_ready), 1);
         tick();
      end

      // Three back-to-back pixels, valid held high, last on the third.
      begin
         int acc_n, sc, rdy_tx, gaps;
         logic started, acc;
         acc_n = 0; sc = 0; rdy_tx = 0; gaps = 0; started = 0;
         pix_valid = 1; pix_data = 24'h123456; pix_last = 0;
         for (int n = 0; n < 3 * PIX_CYC + 20; n++) begin
            @(negedge clk);
            acc = pix_valid && pix_ready;
            if (tx_en) begin
               started = 1;
               sc += int'(bit_strobe);
               if (pix_ready) rdy_tx++;
            end else if (started && !latch) gaps++;
            tick();
            if (acc) begin
               acc_n++;
               if (acc_n == 1) begin pix_data = 24'hFEDCBA; pix_last = 0; end
               else if (acc_n == 2) begin pix_data = 24'h0F0F0F; pix_last = 1; end
               else pix_valid = 0;
            end
         end
         chk("d2_accepts", acc_n, 3);
         chk("d2_bit_periods", sc, 72);
         chk("d2_ready_boundaries", rdy_tx, 2);
         chk("d2_idle_gaps", gaps, 0);
         repeat (RC + 10) tick();
      end

      // Underrun: second pixel withheld.
      begin
         int uc, follow;
         logic prev_u;
         uc = 0; follow = 0; prev_u = 0;
         pix_valid = 1; pix_data = 24'h00FF00; pix_last = 0;
         tick();
         pix_valid = 0;
         for (int n = 0; n < PIX_CYC + 5; n++) begin
            @(negedge clk);
            if (prev_u && latch) follow++;
            prev_u = underrun;
            uc += int'(underrun);
         end
         chk("d3_underrun_pulses", uc, 1);
         chk("d3_latch_follows", follow, 1);
         tick();
         repeat (RC + 5) tick();
      end

      // Reset asserted during bit 10.
      begin
         int uc;
         uc = 0;
         pix_valid = 1; pix_data = 24'hFFFFFF; pix_last = 0;
         tick();
         pix_valid = 0;
         repeat (10 * BP + 3) tick();
         #2 rst = 1;
         #1;
         chk("d4_async_outputs", int'({pix_ready, digit, bit_strobe, tx_en, latch, underrun}), 0);
         repeat (2) begin
            @(posedge clk);
            uc += int'(underrun);
         end
         #1 rst = 0;
         @(negedge clk);
         chk("d4_no_underrun", uc + int'(underrun), 0);
         chk("d4_ready_after_release", int'(pix_ready), 1);
         chk("d4_idle_after_release", int'(tx_en), 0);
         tick();
      end

      // pix_valid held through the latch gap.
      begin
         int lc, idlec, lat_acc;
         logic seen_l, done;
         lc = 0; idlec = 0; lat_acc = 0; seen_l = 0; done = 0;
         pix_valid = 1; pix_data = 24'hC3C3C3; pix_last = 1;
         tick();
         for (int n = 0; n < PIX_CYC + RC + 20 && !done; n++) begin
            pix_data = 24'($urandom);
            @(negedge clk);
            if (latch) begin seen_l = 1; lc++; end
            if (latch && pix_valid && pix_ready) lat_acc++;
            if (seen_l && !latch && !tx_en) idlec++;
            if (seen_l && tx_en) done = 1;
            tick();
         end
         pix_valid = 0;
         chk("d5_restarted", int'(done), 1);
         chk("d5_latch_cycles", lc, RC);
         chk("d5_idle_cycles", idlec, 1);
         chk("d5_latch_accepts", lat_acc, 0);
         repeat (PIX_CYC + RC + 10) tick();
      end

      // Randomized traffic, including stray resets.
      for (int n = 0; n < 15000; n++) begin
         pix_valid = ($urandom_range(0, 3) != 0);
         pix_last  = ($urandom_range(0, 3) == 0);
         pix_data  = 24'($urandom);
         rst       = ($urandom_range(0, 2999) == 0);
         tick();
      end
      rst = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
